// File: rtl/ma_pkg.sv
// Shared constants and FSM encoding for the moving-average window sequencer.
// Optional feature macro used by the top: MA_SEQ_TIMEOUT_EN.
package ma_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_PUBLISH = 2'd3;

  localparam int MA_WINDOW = 20;
  localparam int PRICE_DW  = 16;

  localparam logic [31:0] MA_TIMEOUT_AVG = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_ISSUE   = ST_ISSUE,
    S_WAIT    = ST_WAIT,
    S_PUBLISH = ST_PUBLISH
  } ma_state_t;

  // Width of a counter that must hold the value n itself.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ma_price_ring.sv
// Circular price buffer with write pointer and saturating fill count.
// oldest is the slot about to be overwritten; only meaningful once full.
module ma_price_ring
  import ma_pkg::*;
#(
  parameter int WINDOW = MA_WINDOW,
  parameter int DW     = PRICE_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          flush,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] oldest,
  output logic          full,
  output logic          warm_next
);

  localparam int PW = $clog2(WINDOW);
  localparam int CW = count_width(WINDOW);

  logic [DW-1:0] mem [WINDOW];
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= (wr_ptr == PW'(WINDOW - 1)) ? '0 : wr_ptr + 1'b1;
      if (count != CW'(WINDOW)) count <= count + 1'b1;
    end
  end

  // Contents need no reset: a zero count masks every slot.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= data;
  end

  assign oldest    = mem[wr_ptr];
  assign full      = (count == CW'(WINDOW));
  assign warm_next = (count >= CW'(WINDOW - 1));

endmodule

// File: rtl/ma_window_sequencer.sv
// Front-end controller for the moving-average unit: window bookkeeping,
// start/done handshake and valid/ready result. Optional: MA_SEQ_TIMEOUT_EN.
module ma_window_sequencer
  import ma_pkg::*;
#(
  parameter int WINDOW  = MA_WINDOW,
  parameter int DW      = PRICE_DW
`ifdef MA_SEQ_TIMEOUT_EN
  ,parameter int TIMEOUT = 15
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_price,
  output logic          in_ready,
  output logic          ma_start,
  output logic [DW-1:0] ma_new_price,
  output logic [DW-1:0] ma_oldest_price,
  input  logic [31:0]   ma_moving_avg,
  input  logic          ma_done,
  output logic          avg_valid,
  output logic [31:0]   avg_data,
  output logic          avg_warm,
  input  logic          avg_ready,
  output logic          busy
`ifdef MA_SEQ_TIMEOUT_EN
  ,output logic         timeout_err
`endif
);

  ma_state_t     state;
  logic          run_q;
  logic          flush_pend;
  logic          warm_q;
  logic          accept;
  logic          ring_flush;
  logic [DW-1:0] ring_oldest;
  logic          ring_full;
  logic          ring_warm_next;

`ifdef MA_SEQ_TIMEOUT_EN
  localparam int TW = count_width(TIMEOUT);
  logic [TW-1:0] wait_cnt;
`endif

  // run_q keeps in_ready low while reset is asserted and for the release cycle.
  assign in_ready   = run_q && (state == S_IDLE) && !flush && !flush_pend;
  assign accept     = in_valid && in_ready;
  assign ring_flush = (state == S_IDLE) && (flush || flush_pend);
  assign busy       = (state != S_IDLE);

  ma_price_ring #(
    .WINDOW (WINDOW),
    .DW     (DW)
  ) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .flush     (ring_flush),
    .data      (in_price),
    .oldest    (ring_oldest),
    .full      (ring_full),
    .warm_next (ring_warm_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      run_q           <= 1'b0;
      flush_pend      <= 1'b0;
      warm_q          <= 1'b0;
      ma_start        <= 1'b0;
      ma_new_price    <= '0;
      ma_oldest_price <= '0;
      avg_valid       <= 1'b0;
      avg_data        <= '0;
      avg_warm        <= 1'b0;
`ifdef MA_SEQ_TIMEOUT_EN
      wait_cnt        <= '0;
      timeout_err     <= 1'b0;
`endif
    end else begin
      run_q    <= 1'b1;
      ma_start <= 1'b0;
      if (flush && state != S_IDLE) flush_pend <= 1'b1;
`ifdef MA_SEQ_TIMEOUT_EN
      if (flush) timeout_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          // A pending flush is consumed by the ring on this cycle.
          flush_pend <= 1'b0;
          if (accept) begin
            ma_new_price    <= in_price;
            ma_oldest_price <= ring_full ? ring_oldest : '0;
            warm_q          <= ring_warm_next;
            ma_start        <= 1'b1;
            state           <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef MA_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (ma_done) begin
            avg_data  <= ma_moving_avg;
            avg_warm  <= warm_q;
            avg_valid <= 1'b1;
            state     <= S_PUBLISH;
          end
`ifdef MA_SEQ_TIMEOUT_EN
          else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            avg_data    <= MA_TIMEOUT_AVG;
            avg_warm    <= 1'b0;
            avg_valid   <= 1'b1;
            timeout_err <= 1'b1;
            state       <= S_PUBLISH;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_PUBLISH: begin
          if (avg_ready) begin
            avg_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ma_window_sequencer.sv
// Bench for ma_window_sequencer (WINDOW=4) with a stub averaging unit whose
// result encodes {new_price, oldest_price}; reference is a queue of window prices.
module tb_ma_window_sequencer;

  localparam int W  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_price = '0;
  logic          in_ready;
  logic          ma_start;
  logic [DW-1:0] ma_new_price;
  logic [DW-1:0] ma_oldest_price;
  logic [31:0]   ma_moving_avg;
  logic          ma_done;
  logic          avg_valid;
  logic [31:0]   avg_data;
  logic          avg_warm;
  logic          avg_ready = 1'b0;
  logic          busy;
`ifdef MA_SEQ_TIMEOUT_EN
  logic          timeout_err;
`endif

  ma_window_sequencer #(
    .WINDOW (W),
    .DW     (DW)
`ifdef MA_SEQ_TIMEOUT_EN
    ,.TIMEOUT (15)
`endif
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_price        (in_price),
    .in_ready        (in_ready),
    .ma_start        (ma_start),
    .ma_new_price    (ma_new_price),
    .ma_oldest_price (ma_oldest_price),
    .ma_moving_avg   (ma_moving_avg),
    .ma_done         (ma_done),
    .avg_valid       (avg_valid),
    .avg_data        (avg_data),
    .avg_warm        (avg_warm),
    .avg_ready       (avg_ready),
    .busy            (busy)
`ifdef MA_SEQ_TIMEOUT_EN
    ,.timeout_err    (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  // Stub unit: done two cycles after start, result = {new, oldest} at start.
  logic        stub_off = 1'b0;
  logic        stub_d1;
  logic        stub_done;
  logic [31:0] stub_cap;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_d1   <= 1'b0;
      stub_done <= 1'b0;
      stub_cap  <= '0;
    end else begin
      stub_d1   <= ma_start && !stub_off;
      stub_done <= stub_d1;
      if (ma_start) stub_cap <= {ma_new_price, ma_oldest_price};
    end
  end
  assign ma_done       = stub_done;
  assign ma_moving_avg = stub_cap;

  int start_cnt = 0;
  always @(posedge clk) if (ma_start) start_cnt <= start_cnt + 1;

  int checks = 0;
  int errors = 0;
  int exp_starts = 0;
  logic [DW-1:0] win_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference window update; returns oldest price leaving and warm flag.
  task automatic model_push(input logic [DW-1:0] p, output logic [DW-1:0] old, output logic warm);
    old = (win_q.size() == W) ? win_q[0] : '0;
    win_q.push_back(p);
    if (win_q.size() > W) void'(win_q.pop_front());
    warm = (win_q.size() == W);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_ready_bound"}, in_ready, 1'b1);
  endtask

  // One full transaction; hold = cycles avg_ready stays low; fl = flush pulse mid-transaction.
  task automatic txn(input logic [DW-1:0] p, input int hold, input bit fl);
    logic [DW-1:0] eo;
    logic ew;
    logic [31:0] seen;
    int n;
    wait_ready("txn");
    in_valid = 1'b1;
    in_price = p;
    model_push(p, eo, ew);
    exp_starts++;
    @(negedge clk);
    in_valid = 1'b0;
    check("issue_start", ma_start, 1'b1);
    check("issue_new", ma_new_price, p);
    check("issue_oldest", ma_oldest_price, eo);
    check("issue_busy", busy, 1'b1);
    if (fl) begin flush = 1'b1; @(negedge clk); flush = 1'b0; end
    n = 0;
    while (!avg_valid && n < 50) begin @(negedge clk); n++; end
    check("avg_valid_bound", avg_valid, 1'b1);
    check("avg_data", avg_data, {p, eo});
    check("avg_warm", avg_warm, ew);
    seen = avg_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", avg_valid, 1'b1);
      check("hold_data", avg_data, seen);
      check("hold_in_ready", in_ready, 1'b0);
    end
    avg_ready = 1'b1;
    @(negedge clk);
    avg_ready = 1'b0;
    check("pub_done_valid", avg_valid, 1'b0);
    check("start_count", start_cnt, exp_starts);
    if (fl) begin
      check("flush_pend_ready", in_ready, 1'b0);
      win_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] eo;
    logic ew;
    int snap;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_ma_start", ma_start, 1'b0);
    check("rst_avg_valid", avg_valid, 1'b0);
    check("rst_avg_data", avg_data, 32'h0);
    check("rst_avg_warm", avg_warm, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_new", ma_new_price, '0);
    check("rst_oldest", ma_oldest_price, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill, warm-up and wrap
    txn(16'd10, 0, 0);
    txn(16'd20, 0, 0);
    txn(16'd30, 5, 0);
    txn(16'd40, 0, 0);
    txn(16'd50, 0, 0);
    txn(16'd60, 2, 0);

    // Flush in IDLE beats a simultaneous in_valid
    wait_ready("flush_idle");
    flush = 1'b1;
    in_valid = 1'b1;
    in_price = 16'd99;
    #1;
    check("flush_blocks_ready", in_ready, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_no_accept_busy", busy, 1'b0);
    check("flush_no_accept_start", start_cnt, exp_starts);
    win_q.delete();
    txn(16'd70, 0, 0);

    // Flush during an in-flight transaction, then refill
    txn(16'd80, 1, 1);
    txn(16'd1, 0, 0);
    txn(16'd2, 0, 0);
    txn(16'd3, 0, 0);
    txn(16'd4, 0, 0);
    txn(16'd5, 0, 0);

    // Randomized traffic
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        wait_ready("rand_flush");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        win_q.delete();
      end
      txn(16'($urandom_range(0, 65535)), int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
    end

`ifdef MA_SEQ_TIMEOUT_EN
    begin
      int n;
      stub_off = 1'b1;
      wait_ready("tmo");
      in_valid = 1'b1;
      in_price = 16'd5;
      model_push(16'd5, eo, ew);
      exp_starts++;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!avg_valid && n < 40) begin @(negedge clk); n++; end
      check("tmo_valid", avg_valid, 1'b1);
      check("tmo_err", timeout_err, 1'b1);
      check("tmo_data", avg_data, 32'hFFFF_FFFF);
      check("tmo_warm", avg_warm, 1'b0);
      avg_ready = 1'b1;
      @(negedge clk);
      avg_ready = 1'b0;
      stub_off = 1'b0;
      check("tmo_err_sticky", timeout_err, 1'b1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("tmo_err_cleared", timeout_err, 1'b0);
      win_q.delete();
    end
`endif

    // Asynchronous reset while waiting for done
    wait_ready("rst_mid");
    in_valid = 1'b1;
    in_price = 16'd77;
    model_push(16'd77, eo, ew);
    exp_starts++;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_busy_before", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_start", ma_start, 1'b0);
    check("mid_rst_new", ma_new_price, '0);
    check("mid_rst_oldest", ma_oldest_price, '0);
    check("mid_rst_valid", avg_valid, 1'b0);
    check("mid_rst_ready", in_ready, 1'b0);
    win_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    snap = start_cnt;
    begin
      int stray = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (avg_valid || ma_start) stray++;
      end
      check("post_rst_quiet", stray, 0);
    end
    check("post_rst_starts", start_cnt, snap);
    exp_starts = start_cnt;
    txn(16'd123, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
